// File: rtl/barrel_shifter_arbiter.sv
// rtl/barrel_shifter_arbiter.sv - round-robin arbiter sharing one 8-bit rotate-right datapath
module barrel_shifter_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [3*NREQ-1:0]   req_amt,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [7:0]          res_data,
    output logic [IDW-1:0]      res_id
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [NREQ-1:0] ONE  = NREQ'(1);
    localparam logic [IDW-1:0]  LAST = IDW'(NREQ - 1);

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant;
    logic [IDW:0]   idx;
    logic           found;
    logic           can_accept;
    logic           accept;
    logic [7:0]     sel_data;
    logic [2:0]     sel_amt;
    logic [7:0]     rot_data;
    logic [2:0]     pos;

    // Search from ptr upward, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

    assign can_accept = (state == EMPTY) || res_ready;
    assign req_ready  = (found && can_accept && !rst) ? (ONE << grant) : '0;
    assign accept     = |(req_valid & req_ready);

    assign sel_data = req_data[8*grant +: 8];
    assign sel_amt  = req_amt[3*grant +: 3];

    // Output bit b takes input bit (b + amt) mod 8, which is a right rotate.
    always_comb begin
        rot_data = '0;
        pos      = '0;
        for (int b = 0; b < 8; b++) begin
            pos         = 3'(b) + sel_amt;
            rot_data[b] = sel_data[pos];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (res_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            res_data <= 8'h00;
            res_id   <= '0;
            ptr      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                res_data <= rot_data;
                res_id   <= grant;
                ptr      <= (grant == LAST) ? '0 : grant + 1'b1;
            end
        end
    end

    assign res_valid = (state == FULL);

endmodule

// File: tb/tb_barrel_shifter_arbiter.sv
// tb/tb_barrel_shifter_arbiter.sv - scoreboard bench for barrel_shifter_arbiter
module tb_barrel_shifter_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [3*NREQ-1:0]   req_amt;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic                res_ready;
    logic [7:0]          res_data;
    logic [IDW-1:0]      res_id;

    int n_cmp = 0;
    int n_bad = 0;
    logic [IDW+7:0] exp_q[$];
    logic [IDW+7:0] exp_item;

    always #5 clk = ~clk;

    barrel_shifter_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [7:0] d, input logic [2:0] a);
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = d;
        req_amt[3*i +: 3]  = a;
    endtask

    task automatic drop(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic expect_res(input logic [IDW-1:0] id, input logic [7:0] d);
        exp_q.push_back({id, d});
    endtask

    // Monitor: every completed output handshake is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got id %0d data %0h expected none", res_id, res_data);
            end else begin
                exp_item = exp_q.pop_front();
                chk("res_id", 32'(res_id), 32'(exp_item[IDW+7:8]));
                chk("res_data", 32'(res_data), 32'(exp_item[7:0]));
            end
        end
    end

    logic [IDW-1:0] rr_id  [6];
    logic [7:0]     rr_dat [4];

    initial begin
        rr_id[0] = 2'd0; rr_id[1] = 2'd1; rr_id[2] = 2'd2;
        rr_id[3] = 2'd3; rr_id[4] = 2'd0; rr_id[5] = 2'd1;
        rr_dat[0] = 8'h81; rr_dat[1] = 8'hC0; rr_dat[2] = 8'hC3; rr_dat[3] = 8'h1E;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_amt   = '0;
        res_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'h00);
        chk("rst_res_id", 32'(res_id), 32'd0);
        put(0, 8'hB1, 3'd3);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        tick();

        // Single op
        rst = 1'b0;
        expect_res(0, 8'h36);
        #1;
        chk("single_req_ready", 32'(req_ready), 32'b0001);
        tick();
        drop(0);
        chk("single_res_valid", 32'(res_valid), 32'd1);
        chk("single_res_data", 32'(res_data), 32'h36);
        chk("single_res_id", 32'(res_id), 32'd0);
        tick();
        chk("single_res_empty", 32'(res_valid), 32'd0);

        // Rotate corners
        put(0, 8'hA5, 3'd0); expect_res(0, 8'hA5); tick();
        chk("corner_valid0", 32'(res_valid), 32'd1);
        put(0, 8'h01, 3'd7); expect_res(0, 8'h02); tick();
        chk("corner_valid1", 32'(res_valid), 32'd1);
        put(0, 8'h3C, 3'd4); expect_res(0, 8'hC3); tick();
        drop(0);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Round-robin, all four valid
        put(0, 8'h81, 3'd0);
        put(1, 8'h81, 3'd1);
        put(2, 8'h0F, 3'd2);
        put(3, 8'hF0, 3'd3);
        for (int c = 0; c < 6; c++) begin
            expect_res(rr_id[c], rr_dat[rr_id[c]]);
            #1;
            chk("rr_req_ready", 32'(req_ready), 32'(4'b0001 << rr_id[c]));
            tick();
            chk("rr_no_bubble", 32'(res_valid), 32'd1);
        end

        // Backpressure with id 1 held
        drop(0);
        drop(1);
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_res_data", 32'(res_data), 32'hC0);
            chk("bp_res_id", 32'(res_id), 32'd1);
            tick();
        end
        res_ready = 1'b1;
        expect_res(2, 8'hC3);
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0100);
        tick();
        drop(2);
        expect_res(3, 8'h1E);
        #1;
        chk("bp_next_ready", 32'(req_ready), 32'b1000);
        tick();
        drop(3);
        chk("bp_last_id", 32'(res_id), 32'd3);
        tick();

        // Wrap/skip from ptr=3
        put(2, 8'h55, 3'd1); expect_res(2, 8'hAA); tick();
        drop(2);
        put(1, 8'h12, 3'd4);
        put(3, 8'h80, 3'd7);
        expect_res(3, 8'h01);
        #1;
        chk("wrap_first", 32'(req_ready), 32'b1000);
        tick();
        drop(3);
        expect_res(1, 8'h21);
        #1;
        chk("wrap_second", 32'(req_ready), 32'b0010);
        tick();
        drop(1);
        tick();

        // Reset mid-stream
        put(0, 8'hFF, 3'd0);
        put(1, 8'h96, 3'd1);
        expect_res(0, 8'hFF);
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'b0001);
        tick();
        put(0, 8'hF0, 3'd4);
        rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        chk("post_rst_valid", 32'(res_valid), 32'd0);
        chk("post_rst_data", 32'(res_data), 32'h00);
        chk("post_rst_id", 32'(res_id), 32'd0);
        expect_res(0, 8'h0F);
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        tick();
        drop(0);
        expect_res(1, 8'h4B);
        #1;
        chk("post_rst_grant2", 32'(req_ready), 32'b0010);
        tick();
        drop(1);
        tick();
        tick();
        chk("final_empty", 32'(res_valid), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_arbiter.md
# barrel_shifter_arbiter

Round-robin arbiter and sequencer that shares one 8-bit rotate-right datapath between NREQ requesters. Each requester presents a data byte and a rotate amount under a valid/ready handshake. The block grants one requester per cycle, rotates its byte in a single cycle, and holds the tagged result in an output register. That register is drained by one downstream consumer under its own valid/ready handshake.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- IDW, default 2: requester-ID width, equal to $clog2(NREQ).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  NREQ  bit i set: requester i presents an operation.
- req_data  in  8*NREQ  requester i byte at bits [8i+7:8i].
- req_amt  in  3*NREQ  requester i rotate amount at bits [3i+2:3i].
- req_ready  out  NREQ  one-hot or zero; bit i set: requester i is accepted this cycle.
- res_valid  out  1  output register holds a result.
- res_ready  in  1  consumer takes the result this cycle.
- res_data  out  8  rotated byte.
- res_id  out  IDW  index of the requester that produced res_data.

## Operation
- Rotation is a right rotate by amt: result = {d[amt-1:0], d[7:amt]}.
  - amt=0 passes d through unchanged.
  - amt=7 gives {d[6:0], d[7]}.
- Output-register FSM has two states.
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- can_accept = EMPTY, or (FULL and res_ready).
- Grant rule:
  - g = first i with req_valid[i]=1, searching from index ptr upward and wrapping modulo NREQ.
  - req_ready[g]=1 only when can_accept=1 and rst=0.
  - All other req_ready bits are 0.
  - req_ready is combinational from req_valid, ptr, the FSM state and res_ready. It never depends on req_data or req_amt.
- Accept fires when req_valid[g] and req_ready[g] are both 1. On accept:
  - res_data <= rotated req_data[g].
  - res_id <= g.
  - State goes to FULL.
  - ptr <= (g+1) mod NREQ.
- ptr changes only on accept.
- FSM transitions:
  - EMPTY + accept -> FULL.
  - FULL + res_ready + no accept -> EMPTY.
  - FULL + res_ready + accept -> FULL, loaded with the new result (back-to-back, no bubble).
  - FULL + !res_ready -> FULL. res_data and res_id hold stable and all req_ready bits are 0.
- Requesters keep req_valid, req_data and req_amt stable until accepted. A requester may not withdraw req_valid before it is accepted.
- No starvation: a continuously valid requester is accepted within NREQ accepts.
- Reset values: res_valid=0, res_data=8'h00, res_id=0, ptr=0, state EMPTY, req_ready=0 while rst=1.
- Reset mid-operation: a pending result is discarded and no handshake completes in the reset cycle.

## Timing
- Latency is one cycle: accept at edge N makes res_valid=1 with the result after edge N.
- Throughput is one result per cycle while res_ready=1 and any req_valid=1.
- There is no combinational path from req_* to res_*. The result is always registered.
- The combinational path res_ready -> req_ready is permitted.
- First cycle after rst deasserts: if req_valid is nonzero, requester 0 has highest priority.

## Test plan
- Single op:
  - Stimulus: req_valid=0001, req_data[0]=8'hB1, amt=3, res_ready=1.
  - Response: req_ready=0001 in that cycle; next cycle res_valid=1, res_data=8'h36, res_id=0; res_valid returns to 0 one cycle later.
- Rotate corners:
  - Stimulus: amt=0 on 8'hA5, then amt=7 on 8'h01, then amt=4 on 8'h3C.
  - Response: results 8'hA5, 8'h02, 8'hC3 in consecutive cycles.
- Round-robin:
  - Stimulus: all four requesters hold valid continuously, res_ready=1.
  - Response: res_id sequence 0,1,2,3,0,1 with res_valid=1 every cycle; no bubbles.
- Backpressure:
  - Stimulus: result FULL (id 1), res_ready=0 for 3 cycles, requesters 2 and 3 valid.
  - Response: req_ready=0000, res_data and res_id unchanged for those 3 cycles.
  - Then res_ready=1: requester 2 is accepted in the same cycle, next result res_id=2, then res_id=3.
- Wrap/skip:
  - Stimulus: ptr=3 (after an accept from requester 2); only requesters 1 and 3 valid.
  - Response: grant order 3 then 1.
- Reset mid-stream:
  - Stimulus: rst=1 for one cycle while FULL and requesters valid.
  - Response: next cycle res_valid=0, res_data=8'h00, res_id=0, req_ready=0 during rst; first grant after reset goes to the lowest valid index starting from 0.
